// File: rtl/sid_bus_pkg.sv
// ---------------------------------------------------------------------------
// sid_bus_pkg
// Shared definitions for the SID register write bus: field widths, the tag
// that marks a host byte as an address byte, the {addr, data} command word
// and the register map addresses seen by the voice/envelope/filter decoders.
// ---------------------------------------------------------------------------
package sid_bus_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    // Upper three bits of a host byte that carries a register address.
    localparam logic [2:0] ADDR_TAG = 3'b100;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sid_cmd_t;

    // Assembler states: waiting for the address byte, then the data byte.
    typedef enum logic {
        S_ADDR = 1'b0,
        S_DATA = 1'b1
    } asm_state_e;

    // Register map.
    localparam logic [ADDR_W-1:0] FREQ_LO_1 = 5'h00;
    localparam logic [ADDR_W-1:0] FREQ_HI_1 = 5'h01;
    localparam logic [ADDR_W-1:0] PW_LO_1   = 5'h02;
    localparam logic [ADDR_W-1:0] PW_HI_1   = 5'h03;
    localparam logic [ADDR_W-1:0] CTRL_1    = 5'h04;
    localparam logic [ADDR_W-1:0] AD_1      = 5'h05;
    localparam logic [ADDR_W-1:0] SR_1      = 5'h06;
    localparam logic [ADDR_W-1:0] FREQ_LO_2 = 5'h07;
    localparam logic [ADDR_W-1:0] FREQ_LO_3 = 5'h0E;
    localparam logic [ADDR_W-1:0] FC_LO     = 5'h15;
    localparam logic [ADDR_W-1:0] FC_HI     = 5'h16;
    localparam logic [ADDR_W-1:0] RES_FILT  = 5'h17;
    localparam logic [ADDR_W-1:0] MODE_VOL  = 5'h18;

    // True when a host byte opens a command pair.
    function automatic logic is_addr_byte(input logic [7:0] b);
        return (b[7:5] == ADDR_TAG);
    endfunction

endpackage

// File: rtl/sid_cmd_fifo.sv
// ---------------------------------------------------------------------------
// sid_cmd_fifo
// Synchronous FIFO of sid_cmd_t words. Read data is the current head and is
// valid whenever empty=0. Push and pop may happen in the same cycle.
//
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset (empties the FIFO)
//   push   in  write wdata at the tail (ignored when full)
//   wdata  in  command to write
//   pop    in  remove the head (ignored when empty)
//   rdata  out head command
//   full   out no free entry
//   empty  out no valid entry
// ---------------------------------------------------------------------------
module sid_cmd_fifo
    import sid_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  sid_cmd_t wdata,
    input  logic     pop,
    output sid_cmd_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    sid_cmd_t         mem [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells a wrapped (full) FIFO from an empty one.
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr_q[AW-1:0]];

    // NOTE: every flop is assigned with <= so all registers update together
    // from values sampled at the same edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_W'(1);
            if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
        end
    end

    // NOTE: storage has no reset; emptiness is defined by the pointers alone,
    // so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sid_reg_writer.sv
// ---------------------------------------------------------------------------
// sid_reg_writer
// Host-side master of the SID register write bus. Assembles {address, data}
// pairs from a host byte stream, queues them, and replays each as a one-cycle
// WR strobe with at least GAP idle cycles between strobes.
//
// Ports:
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset
//   iByte    in  host byte
//   iValid   in  iByte valid; accepted when iValid && oReady
//   oReady   out assembler can take a byte this cycle
//   WR       out single-cycle register write strobe
//   ADDR     out register address (held between strobes)
//   DATA     out register data (held between strobes)
//   oBusy    out FIFO non-empty, strobe or gap in progress
//   oErrCnt  out saturating count of framing errors and timeouts
// ---------------------------------------------------------------------------
module sid_reg_writer
    import sid_bus_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 65535,
    parameter int GAP        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        iByte,
    input  logic              iValid,
    output logic              oReady,
    output logic              WR,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DATA,
    output logic              oBusy,
    output logic [7:0]        oErrCnt
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    // ---------------- assembler ----------------
    asm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        err_q;
    logic              run_q;
    logic              err_inc;
    logic              accept;
    logic              push;
    sid_cmd_t          push_cmd;

    // ---------------- FIFO / issuer ----------------
    sid_cmd_t          head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic [GAP_W-1:0]  gap_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_out_q;
    logic [DATA_W-1:0] data_out_q;

    // run_q keeps oReady low through reset and releases it one edge later.
    assign oReady   = run_q && ((state_q == S_ADDR) || !fifo_full);
    assign accept   = iValid && oReady;
    assign push_cmd = '{addr: addr_q, data: iByte};

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tmo_d   = tmo_q;
        push    = 1'b0;
        err_inc = 1'b0;
        unique case (state_q)
            S_ADDR: begin
                if (accept) begin
                    if (is_addr_byte(iByte)) begin
                        addr_d  = iByte[ADDR_W-1:0];
                        tmo_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            S_DATA: begin
                // An accepted data byte takes priority over an expiring timer.
                if (accept) begin
                    push    = 1'b1;
                    state_d = S_ADDR;
                end else if (tmo_q == TMO_LAST) begin
                    err_inc = 1'b1;
                    state_d = S_ADDR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_ADDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_ADDR;
            addr_q  <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
            run_q   <= 1'b1;
            if (err_inc && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
        end
    end

    sid_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The gap counter is loaded on issue and counts down on every following
    // cycle, so the next strobe lands GAP+1 edges after the previous one,
    // leaving GAP idle cycles on the bus.
    assign pop = !fifo_empty && (gap_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q       <= 1'b0;
            gap_q      <= '0;
            addr_out_q <= '0;
            data_out_q <= '0;
        end else begin
            wr_q <= pop;
            if (pop) begin
                addr_out_q <= head.addr;
                data_out_q <= head.data;
                gap_q      <= GAP_W'(GAP);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end
        end
    end

    assign WR      = wr_q;
    assign ADDR    = addr_out_q;
    assign DATA    = data_out_q;
    assign oErrCnt = err_q;
    assign oBusy   = !fifo_empty || wr_q || (gap_q != '0);

endmodule
